// File: rtl/video_in_pkg.sv
// Shared types and constants for the video_in DMA controller.
package video_in_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    BURST     = 2'd2,
    FRAME_END = 2'd3
  } state_t;

  // Wishbone cycle type identifiers used on wb_cti.
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  // Packed 32-bit words per frame: four 8-bit pixels per word.
  function automatic int unsigned frame_words(input int unsigned w, input int unsigned h);
    return (w * h) / 4;
  endfunction

endpackage

// File: rtl/video_in_addr_gen.sv
// Frame buffer selection and Wishbone byte-address generation.
// Buffers are laid out back to back from base_addr; the address wraps mod 2^32.
module video_in_addr_gen
  import video_in_pkg::*;
#(
  parameter int p_NBUF        = 2,
  parameter int p_FRAME_WORDS = 76800,
  parameter int p_BUFW        = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [31:0]       base_addr,
  input  logic              load,     // point adr at the start of cur_buf
  input  logic              incr,     // advance adr by one 32-bit word
  input  logic              advance,  // move on to the next buffer
  output logic [p_BUFW-1:0] cur_buf,
  output logic [31:0]       adr
);

  localparam logic [31:0]       FRAME_BYTES = 32'(p_FRAME_WORDS * 4);
  localparam logic [p_BUFW-1:0] LAST_BUF    = p_BUFW'(p_NBUF - 1);

  logic [31:0] frame_base;

  // Start address of the buffer currently selected.
  always_comb begin
    frame_base = base_addr + (32'(cur_buf) * FRAME_BYTES);
  end

  // Buffer index rotation and word address counter.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      cur_buf <= '0;
      adr     <= '0;
    end else begin
      if (advance) begin
        cur_buf <= (cur_buf == LAST_BUF) ? '0 : cur_buf + p_BUFW'(1);
      end
      if (load) begin
        adr <= frame_base;
      end else if (incr) begin
        adr <= adr + 32'd4;
      end
    end
  end

endmodule

// File: rtl/video_in_dma_ctrl.sv
// Drains the packed-pixel capture FIFO into rotating frame buffers using
// Wishbone incrementing bursts of p_BURST words.
//
// Handshake: wb_stb is the valid and wb_ack the ready of each beat. A beat
// transfers on a posedge where wb_stb=1 and wb_ack=1; until then wb_stb,
// wb_adr, wb_dat_o and wb_cti are held. The FIFO head is popped in the same
// cycle as the accepting ack (fifo_re = wb_ack during a burst), so wb_dat_o
// always shows the word that the next ack will consume.
module video_in_dma_ctrl
  import video_in_pkg::*;
#(
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480,
  parameter int p_BURST  = 8,
  parameter int p_NBUF   = 2,
  parameter int p_LVLW   = 6
) (
  input  logic                                         clk,
  input  logic                                         nRST,
  input  logic                                         enable,
  input  logic [31:0]                                  base_addr,
  input  logic [p_LVLW-1:0]                            fifo_level,
  input  logic                                         fifo_full,
  input  logic [31:0]                                  fifo_rdata,
  output logic                                         fifo_re,
  output logic                                         wb_cyc,
  output logic                                         wb_stb,
  output logic                                         wb_we,
  output logic [31:0]                                  wb_adr,
  output logic [31:0]                                  wb_dat_o,
  output logic [3:0]                                   wb_sel,
  output logic [2:0]                                   wb_cti,
  input  logic                                         wb_ack,
  output logic [(p_NBUF > 1 ? $clog2(p_NBUF) : 1)-1:0] cur_buf,
  output logic                                         frame_done,
  output logic                                         overrun,
  output logic [1:0]                                   dbg_state
);

  localparam int FRAME_WORDS = frame_words(p_WIDTH, p_HEIGHT);
  localparam int WCW         = $clog2(FRAME_WORDS + 1);
  localparam int BCW         = (p_BURST > 1) ? $clog2(p_BURST) : 1;
  localparam int BUFW        = (p_NBUF > 1) ? $clog2(p_NBUF) : 1;

  localparam logic [p_LVLW-1:0] LVL_BURST  = p_LVLW'(p_BURST);
  localparam logic [BCW-1:0]    BEAT_LAST  = BCW'(p_BURST - 1);
  localparam logic [BCW-1:0]    BEAT_PRE   = BCW'(p_BURST - 2);
  localparam logic [WCW-1:0]    WORD_LAST  = WCW'(FRAME_WORDS - 1);
  localparam logic [2:0]        CTI_FIRST  = (p_BURST == 1) ? CTI_EOB : CTI_INCR;

  state_t         state;
  logic [WCW-1:0] word_cnt;
  logic [BCW-1:0] beat_cnt;

  logic           beat_ok;
  logic           last_beat;
  logic           frame_last;
  logic           adr_load;
  logic           buf_advance;
  logic [31:0]    adr;

  // Beat acceptance and the address-generator control strobes.
  always_comb begin
    beat_ok     = (state == BURST) && wb_ack;
    last_beat   = (beat_cnt == BEAT_LAST);
    frame_last  = (word_cnt == WORD_LAST);
    adr_load    = enable && ((state == IDLE) || (state == FRAME_END));
    buf_advance = beat_ok && last_beat && frame_last;
  end

  video_in_addr_gen #(
    .p_NBUF        (p_NBUF),
    .p_FRAME_WORDS (FRAME_WORDS),
    .p_BUFW        (BUFW)
  ) u_addr_gen (
    .clk       (clk),
    .nRST      (nRST),
    .base_addr (base_addr),
    .load      (adr_load),
    .incr      (beat_ok),
    .advance   (buf_advance),
    .cur_buf   (cur_buf),
    .adr       (adr)
  );

  // Sequencer: waits for a burst's worth of FIFO data, runs the burst,
  // and closes the frame once every word has been written.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      word_cnt   <= '0;
      beat_cnt   <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_cti     <= 3'b000;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fifo_full && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= WAIT;
            word_cnt <= '0;
            overrun  <= 1'b0;
          end
        end
        WAIT: begin
          if (fifo_level >= LVL_BURST) begin
            state    <= BURST;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            beat_cnt <= '0;
            wb_cti   <= CTI_FIRST;
          end
        end
        BURST: begin
          if (wb_ack) begin
            word_cnt <= word_cnt + WCW'(1);
            beat_cnt <= beat_cnt + BCW'(1);
            wb_cti   <= (beat_cnt == BEAT_PRE) ? CTI_EOB : CTI_INCR;
            if (last_beat) begin
              wb_cyc   <= 1'b0;
              wb_stb   <= 1'b0;
              wb_cti   <= 3'b000;
              beat_cnt <= '0;
              if (frame_last) begin
                state      <= FRAME_END;
                frame_done <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        FRAME_END: begin
          word_cnt <= '0;
          state    <= enable ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs that follow the registered cycle flag.
  always_comb begin
    fifo_re   = beat_ok;
    wb_we     = wb_cyc;
    wb_sel    = {4{wb_cyc}};
    wb_dat_o  = wb_cyc ? fifo_rdata : 32'h0;
    wb_adr    = adr;
    dbg_state = state;
  end

endmodule
